lcd_hd44780_responder: RTL and testbench

- Synthesizable responder for the HD44780-style 16x2 character LCD bus that `LCD_Display` drives (8-bit data, RS/RW/E).
- Sits on the far end of the LCD pins, in place of the panel, in simulation benches and in on-chip loopback builds.
- Decodes the command and data writes the controller issues, holds the 32 visible characters in a DDRAM shadow, and emulates the busy flag.
- Exposes the shadow through a debug read port so benches can compare the displayed text with the expected text.

---
 rtl/lcd_hd44780_responder_if.sv | 10 +
 rtl/lcd_hd44780_responder.sv | 196 +++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_responder_if.sv
// Control strobes of the HD44780 LCD bus (E, RS, RW) between controller and responder.
// The 8-bit data bus is tri-stated, so it stays a plain inout on the responder.
interface lcd_hd44780_responder_if;
  logic LCD_E;
  logic LCD_RS;
  logic LCD_RW;

  modport master (output LCD_E, output LCD_RS, output LCD_RW);
  modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW);
endinterface

// File: rtl/lcd_hd44780_responder.sv
// HD44780 16x2 panel stand-in: decodes controller writes into a DDRAM shadow and emulates busy.
// Define LCD_RESP_READ_EN to support read cycles (busy/address and DDRAM reads on DATA_BUS).
module lcd_hd44780_responder #(
  parameter int unsigned EXEC_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic                   iCLK_50MHZ,
  input  logic                   iRST_N,
  lcd_hd44780_responder_if.slave lcd,
  inout  wire  [7:0]             DATA_BUS,
  input  logic [4:0]             dbg_slot,
  output logic [7:0]             dbg_char,
  output logic [6:0]             cursor_addr,
  output logic                   busy,
  output logic                   display_on,
  output logic                   protocol_err
);
  localparam int unsigned MAX_CYCLES = (EXEC_CYCLES > CLEAR_CYCLES) ? EXEC_CYCLES : CLEAR_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYCLES);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYCLES);
  localparam logic [7:0]       BLANK    = 8'h20;

  logic [1:0]       e_sync_q, rs_sync_q, rw_sync_q;
  logic [7:0]       data_meta_q, data_sync_q;
  logic             e_dly_q;
  logic             fall_e;
  logic [7:0]       ddram_q [32];
  logic [6:0]       cursor_q, cursor_d;
  logic             inc_q, inc_d;
  logic             disp_q, disp_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic [4:0]       fill_idx_q, fill_idx_d;
  logic             mem_we;
  logic [4:0]       mem_idx;
  logic [7:0]       mem_wdata;

  // DDRAM address walk: line 1 ends at 0x27 and wraps into line 2 at 0x40, and vice versa.
  function automatic logic [6:0] step_addr(input logic [6:0] addr, input logic up);
    logic [6:0] nxt;
    if (up) begin
      if (addr == 7'h27)      nxt = 7'h40;
      else if (addr == 7'h67) nxt = 7'h00;
      else                    nxt = addr + 7'd1;
    end else begin
      if (addr == 7'h00)      nxt = 7'h67;
      else if (addr == 7'h40) nxt = 7'h27;
      else                    nxt = addr - 7'd1;
    end
    return nxt;
  endfunction

  // Visible columns are 0x00-0x0F and 0x40-0x4F.
  function automatic logic on_screen(input logic [6:0] addr);
    return addr[5:4] == 2'b00;
  endfunction

  function automatic logic [4:0] slot_of(input logic [6:0] addr);
    return {addr[6], addr[3:0]};
  endfunction

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      e_sync_q    <= '0;
      rs_sync_q   <= '0;
      rw_sync_q   <= '0;
      data_meta_q <= '0;
      data_sync_q <= '0;
      e_dly_q     <= 1'b0;
    end else begin
      e_sync_q    <= {e_sync_q[0], lcd.LCD_E};
      rs_sync_q   <= {rs_sync_q[0], lcd.LCD_RS};
      rw_sync_q   <= {rw_sync_q[0], lcd.LCD_RW};
      data_meta_q <= DATA_BUS;
      data_sync_q <= data_meta_q;
      e_dly_q     <= e_sync_q[1];
    end
  end

  assign fall_e = e_dly_q & ~e_sync_q[1];
  assign busy   = (cnt_q != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    cursor_d   = cursor_q;
    inc_d      = inc_q;
    disp_d     = disp_q;
    err_d      = err_q;
    cnt_d      = busy ? cnt_q - CNT_W'(1) : cnt_q;
    fill_d     = fill_q;
    fill_idx_d = fill_idx_q;
    mem_we     = 1'b0;
    mem_idx    = fill_idx_q;
    mem_wdata  = BLANK;

    if (fill_q) begin
      mem_we     = 1'b1;
      fill_idx_d = fill_idx_q + 5'd1;
      if (fill_idx_q == 5'd31) fill_d = 1'b0;
    end

    if (fall_e && !rw_sync_q[1]) begin
      // The cycle where the counter drops to zero still reports busy.
      if (busy) begin
        err_d = 1'b1;
      end else if (rs_sync_q[1]) begin
        if (on_screen(cursor_q)) begin
          mem_we    = 1'b1;
          mem_idx   = slot_of(cursor_q);
          mem_wdata = data_sync_q;
        end
        cursor_d = step_addr(cursor_q, inc_q);
        cnt_d    = EXEC_LD;
      end else begin
        casez (data_sync_q)
          8'b1???????: begin cursor_d = data_sync_q[6:0]; cnt_d = EXEC_LD; end
          8'b01??????,
          8'b001?????: cnt_d = EXEC_LD;
          8'b0001????: begin
            if (!data_sync_q[3]) cursor_d = step_addr(cursor_q, data_sync_q[2]);
            cnt_d = EXEC_LD;
          end
          8'b00001???: begin disp_d = data_sync_q[2]; cnt_d = EXEC_LD; end
          8'b000001??: begin inc_d  = data_sync_q[1]; cnt_d = EXEC_LD; end
          8'b0000001?: begin cursor_d = '0; cnt_d = CLEAR_LD; end
          8'b00000001: begin
            cursor_d   = '0;
            inc_d      = 1'b1;
            fill_d     = 1'b1;
            fill_idx_d = '0;
            cnt_d      = CLEAR_LD;
          end
          default: ;
        endcase
      end
    end
`ifdef LCD_RESP_READ_EN
    else if (fall_e && rs_sync_q[1]) begin
      cursor_d = step_addr(cursor_q, inc_q);
    end
`endif
  end

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      cursor_q   <= '0;
      inc_q      <= 1'b1;
      disp_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      fill_q     <= 1'b0;
      fill_idx_q <= '0;
    end else begin
      cursor_q   <= cursor_d;
      inc_q      <= inc_d;
      disp_q     <= disp_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      fill_idx_q <= fill_idx_d;
    end
  end

  // NOTE: the shadow is reset like ordinary flops because a reset mid-fill must
  // show blanks immediately; it is small enough to live in registers, not a RAM macro.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 32; i++) ddram_q[i] <= BLANK;
    end else if (mem_we) begin
      ddram_q[mem_idx] <= mem_wdata;
    end
  end

  assign dbg_char     = ddram_q[dbg_slot];
  assign cursor_addr  = cursor_q;
  assign display_on   = disp_q;
  assign protocol_err = err_q;

`ifdef LCD_RESP_READ_EN
  logic [7:0] rd_byte;

  always_comb begin
    if (rs_sync_q[1]) rd_byte = on_screen(cursor_q) ? ddram_q[slot_of(cursor_q)] : BLANK;
    else              rd_byte = {busy, cursor_q};
  end

  assign DATA_BUS = (e_sync_q[1] && rw_sync_q[1]) ? rd_byte : 8'bz;
`else
  assign DATA_BUS = 8'bz;
`endif
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder: command/data vector table with a
// scoreboard queue, plus sequences for busy-boundary, protocol error, reset and reads.
module tb_lcd_hd44780_responder;
  localparam int EXEC = 64;
  localparam int CLR  = 600;
  localparam int NV   = 37;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_drv;
  logic [7:0] tb_data;
  wire  [7:0] data_bus;
  logic [4:0] dbg_slot;
  logic [7:0] dbg_char;
  logic [6:0] cursor_addr;
  logic       busy, display_on, protocol_err;

  always #10 clk = ~clk;

  lcd_hd44780_responder_if lcd_if ();
  assign data_bus = tb_drv ? tb_data : 8'bz;

  lcd_hd44780_responder #(.EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLR)) dut (
    .iCLK_50MHZ  (clk),
    .iRST_N      (rst_n),
    .lcd         (lcd_if),
    .DATA_BUS    (data_bus),
    .dbg_slot    (dbg_slot),
    .dbg_char    (dbg_char),
    .cursor_addr (cursor_addr),
    .busy        (busy),
    .display_on  (display_on),
    .protocol_err(protocol_err)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy_cyc;
    logic [6:0] cursor;
    logic [4:0] slot;
    logic [7:0] ch;
    logic       disp;
  } vec_t;

  vec_t tbl [NV];
  vec_t sb [$];
  int   n_checks = 0;
  int   n_errs   = 0;

  function automatic vec_t mk(input logic rs, input logic [7:0] d, input int bc,
                              input logic [6:0] cur, input logic [4:0] sl,
                              input logic [7:0] ch, input logic disp);
    vec_t v;
    v.rs = rs; v.data = d; v.busy_cyc = bc; v.cursor = cur;
    v.slot = sl; v.ch = ch; v.disp = disp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_slot(input string name, input logic [4:0] sl, input logic [7:0] exp);
    dbg_slot = sl;
    #1;
    check(name, dbg_char, exp);
  endtask

  task automatic bus_start(input logic rs, input logic rw, input logic [7:0] d, input logic drive);
    lcd_if.LCD_RS = rs;
    lcd_if.LCD_RW = rw;
    tb_data       = d;
    tb_drv        = drive;
    lcd_if.LCD_E  = 1'b1;
  endtask

  // Returns on the negedge where E falls; RS/RW/DATA keep their values afterwards.
  task automatic write_launch(input logic rs, input logic [7:0] d);
    @(negedge clk);
    bus_start(rs, 1'b0, d, 1'b1);
    repeat (6) @(negedge clk);
    lcd_if.LCD_E = 1'b0;
  endtask

  // Counts the busy cycles that follow the write (0 when busy never rises).
  task automatic write_measure(input logic rs, input logic [7:0] d, output int cyc);
    write_launch(rs, d);
    cyc = 0;
    for (int i = 0; i < 8 && !busy; i++) @(negedge clk);
    while (busy && cyc < CLR + 8) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < CLR + 50 && busy; i++) @(negedge clk);
    check(name, busy, 1'b0);
  endtask

  task automatic do_read(input logic rs, input logic drive_zero, output logic [7:0] v);
    @(negedge clk);
    bus_start(rs, 1'b1, 8'h00, drive_zero);
    repeat (5) @(negedge clk);
    v = data_bus;
    lcd_if.LCD_E = 1'b0;
    repeat (5) @(negedge clk);
    lcd_if.LCD_RW = 1'b0;
    tb_drv        = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    lcd_if.LCD_E  = 1'b0;
    lcd_if.LCD_RS = 1'b0;
    lcd_if.LCD_RW = 1'b0;
    tb_drv        = 1'b1;
    tb_data       = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #(20 * 200000);
    $display("Watchdog expired: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int         cyc;
    logic [7:0] v;

    rst_n = 1'b0;
    lcd_if.LCD_E = 1'b0; lcd_if.LCD_RS = 1'b0; lcd_if.LCD_RW = 1'b0;
    tb_drv = 1'b1; tb_data = 8'h00; dbg_slot = 5'd0;

    //               rs  data   busy  cursor slot   char   disp
    tbl[0]  = mk(1'b0, 8'h01, CLR,  7'h00, 5'd0,  8'h20, 1'b0);
    tbl[1]  = mk(1'b0, 8'h0C, EXEC, 7'h00, 5'd0,  8'h20, 1'b1);
    tbl[2]  = mk(1'b0, 8'h38, EXEC, 7'h00, 5'd0,  8'h20, 1'b1);
    tbl[3]  = mk(1'b0, 8'h06, EXEC, 7'h00, 5'd0,  8'h20, 1'b1);
    tbl[4]  = mk(1'b0, 8'h80, EXEC, 7'h00, 5'd0,  8'h20, 1'b1);
    tbl[5]  = mk(1'b1, 8'h48, EXEC, 7'h01, 5'd0,  8'h48, 1'b1);
    tbl[6]  = mk(1'b1, 8'h49, EXEC, 7'h02, 5'd1,  8'h49, 1'b1);
    tbl[7]  = mk(1'b0, 8'hC0, EXEC, 7'h40, 5'd16, 8'h20, 1'b1);
    tbl[8]  = mk(1'b1, 8'h41, EXEC, 7'h41, 5'd16, 8'h41, 1'b1);
    tbl[9]  = mk(1'b0, 8'hA7, EXEC, 7'h27, 5'd16, 8'h41, 1'b1);
    tbl[10] = mk(1'b1, 8'h42, EXEC, 7'h40, 5'd16, 8'h41, 1'b1);
    tbl[11] = mk(1'b1, 8'h43, EXEC, 7'h41, 5'd16, 8'h43, 1'b1);
    tbl[12] = mk(1'b0, 8'h10, EXEC, 7'h40, 5'd16, 8'h43, 1'b1);
    tbl[13] = mk(1'b0, 8'h10, EXEC, 7'h27, 5'd16, 8'h43, 1'b1);
    tbl[14] = mk(1'b0, 8'h14, EXEC, 7'h40, 5'd16, 8'h43, 1'b1);
    tbl[15] = mk(1'b0, 8'h18, EXEC, 7'h40, 5'd16, 8'h43, 1'b1);
    tbl[16] = mk(1'b0, 8'h04, EXEC, 7'h40, 5'd16, 8'h43, 1'b1);
    tbl[17] = mk(1'b0, 8'h80, EXEC, 7'h00, 5'd0,  8'h48, 1'b1);
    tbl[18] = mk(1'b0, 8'h00, 0,    7'h00, 5'd0,  8'h48, 1'b1);
    tbl[19] = mk(1'b0, 8'h10, EXEC, 7'h67, 5'd0,  8'h48, 1'b1);
    tbl[20] = mk(1'b0, 8'h14, EXEC, 7'h00, 5'd0,  8'h48, 1'b1);
    tbl[21] = mk(1'b0, 8'hC0, EXEC, 7'h40, 5'd16, 8'h43, 1'b1);
    tbl[22] = mk(1'b1, 8'h5A, EXEC, 7'h27, 5'd16, 8'h5A, 1'b1);
    tbl[23] = mk(1'b0, 8'h06, EXEC, 7'h27, 5'd16, 8'h5A, 1'b1);
    tbl[24] = mk(1'b0, 8'hE7, EXEC, 7'h67, 5'd16, 8'h5A, 1'b1);
    tbl[25] = mk(1'b1, 8'h31, EXEC, 7'h00, 5'd0,  8'h48, 1'b1);
    tbl[26] = mk(1'b0, 8'hFF, EXEC, 7'h7F, 5'd0,  8'h48, 1'b1);
    tbl[27] = mk(1'b0, 8'h14, EXEC, 7'h00, 5'd0,  8'h48, 1'b1);
    tbl[28] = mk(1'b0, 8'hA8, EXEC, 7'h28, 5'd0,  8'h48, 1'b1);
    tbl[29] = mk(1'b0, 8'h10, EXEC, 7'h27, 5'd0,  8'h48, 1'b1);
    tbl[30] = mk(1'b0, 8'h02, CLR,  7'h00, 5'd0,  8'h48, 1'b1);
    tbl[31] = mk(1'b0, 8'h08, EXEC, 7'h00, 5'd1,  8'h49, 1'b0);
    tbl[32] = mk(1'b0, 8'h40, EXEC, 7'h00, 5'd1,  8'h49, 1'b0);
    tbl[33] = mk(1'b0, 8'h04, EXEC, 7'h00, 5'd1,  8'h49, 1'b0);
    tbl[34] = mk(1'b0, 8'h01, CLR,  7'h00, 5'd16, 8'h20, 1'b0);
    tbl[35] = mk(1'b1, 8'h55, EXEC, 7'h01, 5'd0,  8'h55, 1'b0);
    tbl[36] = mk(1'b1, 8'h56, EXEC, 7'h02, 5'd1,  8'h56, 1'b0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset cursor", cursor_addr, 7'h00);
    check("reset display_on", display_on, 1'b0);
    check("reset protocol_err", protocol_err, 1'b0);
    check_slot("reset slot0", 5'd0, 8'h20);
    check_slot("reset slot31", 5'd31, 8'h20);

    for (int i = 0; i < NV; i++) begin
      vec_t e;
      sb.push_back(tbl[i]);
      write_measure(tbl[i].rs, tbl[i].data, cyc);
      e = sb.pop_front();
      check($sformatf("v%0d busy_cycles", i), cyc, e.busy_cyc);
      check($sformatf("v%0d cursor", i), cursor_addr, e.cursor);
      check($sformatf("v%0d display_on", i), display_on, e.disp);
      check($sformatf("v%0d protocol_err", i), protocol_err, 1'b0);
      check_slot($sformatf("v%0d slot%0d", i, e.slot), e.slot, e.ch);
    end

    // Second data write lands while the first is still busy.
    write_launch(1'b1, 8'h58);
    repeat (10) @(negedge clk);
    write_launch(1'b1, 8'h59);
    repeat (6) @(negedge clk);
    check("busy write protocol_err", protocol_err, 1'b1);
    check("busy write cursor", cursor_addr, 7'h03);
    check_slot("busy write slot2", 5'd2, 8'h58);
    check_slot("busy write slot3", 5'd3, 8'h20);
    wait_idle("busy write idle");
    write_measure(1'b0, 8'h80, cyc);
    check("sticky err busy_cycles", cyc, EXEC);
    check("sticky protocol_err", protocol_err, 1'b1);
    check("sticky cursor", cursor_addr, 7'h00);

    // fall_e on the last busy cycle is rejected; one cycle later it is accepted.
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      write_launch(1'b1, 8'h61);
      for (int i = 0; i < 8 && !busy; i++) @(negedge clk);
      repeat (EXEC - 10) @(negedge clk);
      bus_start(1'b1, 1'b0, 8'h62, 1'b1);
      repeat (7 + k) @(negedge clk);
      lcd_if.LCD_E = 1'b0;
      repeat (4) @(negedge clk);
      wait_idle($sformatf("edge%0d idle", k));
      check($sformatf("edge%0d protocol_err", k), protocol_err, (k == 0));
      check($sformatf("edge%0d cursor", k), cursor_addr, (k == 0) ? 7'h01 : 7'h02);
      check_slot($sformatf("edge%0d slot0", k), 5'd0, 8'h61);
      check_slot($sformatf("edge%0d slot1", k), 5'd1, (k == 0) ? 8'h20 : 8'h62);
    end

    // Reset during the clear fill.
    apply_reset();
    write_measure(1'b0, 8'h0C, cyc);
    write_measure(1'b0, 8'hCF, cyc);
    write_measure(1'b1, 8'h7A, cyc);
    check_slot("preclear slot31", 5'd31, 8'h7A);
    write_launch(1'b0, 8'h01);
    repeat (8) @(negedge clk);
    check("midclear busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midclear reset busy", busy, 1'b0);
    check("midclear reset cursor", cursor_addr, 7'h00);
    check("midclear reset display_on", display_on, 1'b0);
    check_slot("midclear reset slot31", 5'd31, 8'h20);
    lcd_if.LCD_E = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    write_measure(1'b1, 8'h21, cyc);
    check("postreset busy_cycles", cyc, EXEC);
    check("postreset cursor", cursor_addr, 7'h01);
    check_slot("postreset slot0", 5'd0, 8'h21);

`ifdef LCD_RESP_READ_EN
    apply_reset();
    write_measure(1'b0, 8'h80, cyc);
    write_launch(1'b1, 8'h44);
    repeat (5) @(negedge clk);
    do_read(1'b0, 1'b0, v);
    check("read busy flag", v, 8'h81);
    wait_idle("read idle");
    do_read(1'b0, 1'b0, v);
    check("read idle flag", v, 8'h01);
    check("read protocol_err", protocol_err, 1'b0);
    write_measure(1'b0, 8'h80, cyc);
    do_read(1'b1, 1'b0, v);
    check("read ddram", v, 8'h44);
    check("read step cursor", cursor_addr, 7'h01);
    check("read no busy", busy, 1'b0);
    write_measure(1'b0, 8'hB0, cyc);
    do_read(1'b1, 1'b0, v);
    check("read offscreen", v, 8'h20);
    check("read offscreen cursor", cursor_addr, 7'h31);
    check("read final protocol_err", protocol_err, 1'b0);
`else
    apply_reset();
    write_measure(1'b0, 8'h85, cyc);
    do_read(1'b0, 1'b1, v);
    check("noread bus rs0", v, 8'h00);
    do_read(1'b1, 1'b1, v);
    check("noread bus rs1", v, 8'h00);
    check("noread cursor", cursor_addr, 7'h05);
    check("noread protocol_err", protocol_err, 1'b0);
    check("noread busy", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
